// File: rtl/key_repeat_filter_if.sv
// key_repeat_filter_if: bundles the PS/2 byte input, the repeat enable and
// the cleaned key-event outputs of key_repeat_filter.
//
// Signals:
//   ps2_code   - received scan-code byte, qualified by ps2_valid
//   ps2_valid  - one-cycle strobe for a new byte
//   repeat_en  - level, 1 enables auto-repeat pulses
//   key_pulse  - one-cycle key event strobe (initial press or repeat)
//   key_code   - code of the currently or last held key
//   key_ext    - held key was E0-prefixed
//   key_down   - a key is currently held
//   stable_key - key_code stretched after each pulse, 0 otherwise
//
// Handshake: ps2_valid is a strobe with no ready. The filter accepts a byte
// on every rising clock edge where ps2_valid is 1, and ps2_code only matters
// on those edges. key_pulse is likewise a strobe with no back-pressure; the
// consumer must take it in the cycle it is high.
//
// Modports: master drives the byte stream and repeat_en (receiver side or
// bench), slave is the filter itself.

interface key_repeat_filter_if #(
  parameter int CODE_W = 8
);
  logic [CODE_W-1:0] ps2_code;
  logic              ps2_valid;
  logic              repeat_en;
  logic              key_pulse;
  logic [CODE_W-1:0] key_code;
  logic              key_ext;
  logic              key_down;
  logic [CODE_W-1:0] stable_key;

  modport master (
    output ps2_code, ps2_valid, repeat_en,
    input  key_pulse, key_code, key_ext, key_down, stable_key
  );

  modport slave (
    input  ps2_code, ps2_valid, repeat_en,
    output key_pulse, key_code, key_ext, key_down, stable_key
  );
endinterface

// File: rtl/key_repeat_filter.sv
// key_repeat_filter: turns raw one-cycle PS/2 scan-code strobes into clean
// game key events. Decodes E0 (extended) and F0 (break) prefixes, tracks the
// held key, drops keyboard typematic duplicates, generates its own
// programmable auto-repeat and stretches the key code into a level output
// for slow-clock consumers.
//
// Ports:
//   clock     - system clock, rising edge
//   resetn    - asynchronous active-low reset
//   bus       - key_repeat_filter_if.slave (PS/2 input, repeat_en, outputs)
//   dbg_state - current repeat FSM state (0 IDLE, 1 DELAY, 2 REPEAT)
//
// Timing: a byte strobed in cycle n produces key_pulse in cycle n+1. The
// first repeat pulse follows the make pulse by REPEAT_DELAY cycles, later
// ones are REPEAT_PERIOD cycles apart.

module key_repeat_filter #(
  parameter int CODE_W        = 8,
  parameter int CNT_W         = 24,
  parameter int HOLD_CYCLES   = 5000000,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                  clock,
  input  logic                  resetn,
  key_repeat_filter_if.slave    bus,
  output logic [1:0]            dbg_state
);

  // Elaboration-time parameter checks: zero counts have no meaning and every
  // load value must fit the timer width.
  if (HOLD_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_zero_count
    $error("key_repeat_filter: count parameters must be non-zero");
  end
  if (CNT_W < 31 && (HOLD_CYCLES > (1 << CNT_W) || REPEAT_DELAY > (1 << CNT_W) ||
                     REPEAT_PERIOD > (1 << CNT_W))) begin : g_cnt_width
    $error("key_repeat_filter: CNT_W too small for count parameters");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]  PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  localparam logic [CODE_W-1:0] BYTE_E0 = CODE_W'(8'hE0);
  localparam logic [CODE_W-1:0] BYTE_F0 = CODE_W'(8'hF0);
  localparam logic [CODE_W-1:0] BYTE_00 = CODE_W'(8'h00);
  localparam logic [CODE_W-1:0] BYTE_AA = CODE_W'(8'hAA);
  localparam logic [CODE_W-1:0] BYTE_EE = CODE_W'(8'hEE);
  localparam logic [CODE_W-1:0] BYTE_FA = CODE_W'(8'hFA);
  localparam logic [CODE_W-1:0] BYTE_FF = CODE_W'(8'hFF);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic              brk_pend_q, brk_pend_d;
  logic              ext_pend_q, ext_pend_d;
  logic              pulse_q, pulse_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              kext_q, kext_d;
  logic              down_q, down_d;
  logic [CODE_W-1:0] stable_q, stable_d;

  // Byte classification
  logic is_e0, is_f0, is_ignored, key_evt, held_match, make_new, brk_match;

  assign is_e0      = bus.ps2_valid && (bus.ps2_code == BYTE_E0);
  assign is_f0      = bus.ps2_valid && (bus.ps2_code == BYTE_F0);
  // Keyboard housekeeping bytes (ack, BAT, echo, errors) are not key events.
  assign is_ignored = (bus.ps2_code == BYTE_00) || (bus.ps2_code == BYTE_AA) ||
                      (bus.ps2_code == BYTE_EE) || (bus.ps2_code == BYTE_FA) ||
                      (bus.ps2_code == BYTE_FF);
  assign key_evt    = bus.ps2_valid && !is_e0 && !is_f0 && !is_ignored;

  // A key is identified by code plus E0 flag; only a held key can match.
  assign held_match = down_q && (bus.ps2_code == code_q) && (ext_pend_q == kext_q);
  // A make of the held key is keyboard typematic and is swallowed.
  assign make_new   = key_evt && !brk_pend_q && !held_match;
  assign brk_match  = key_evt &&  brk_pend_q &&  held_match;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      hold_q     <= '0;
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
      pulse_q    <= 1'b0;
      code_q     <= '0;
      kext_q     <= 1'b0;
      down_q     <= 1'b0;
      stable_q   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
      brk_pend_q <= brk_pend_d;
      ext_pend_q <= ext_pend_d;
      pulse_q    <= pulse_d;
      code_q     <= code_d;
      kext_q     <= kext_d;
      down_q     <= down_d;
      stable_q   <= stable_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    hold_d     = hold_q;
    brk_pend_d = brk_pend_q;
    ext_pend_d = ext_pend_q;
    pulse_d    = 1'b0;
    code_d     = code_q;
    kext_d     = kext_q;
    down_d     = down_q;
    stable_d   = stable_q;

    // Prefix tracking: flags accumulate until a key event consumes them.
    if (is_e0) ext_pend_d = 1'b1;
    if (is_f0) brk_pend_d = 1'b1;
    if (key_evt) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end

    // Accepted key events take priority over a repeat expiring this cycle.
    // Ignored events (typematic make, foreign break) leave the timer alone.
    if (make_new) begin
      code_d  = bus.ps2_code;
      kext_d  = ext_pend_q;
      down_d  = 1'b1;
      pulse_d = 1'b1;
      timer_d = DELAY_LOAD;
      state_d = DELAY;
    end else if (brk_match) begin
      down_d  = 1'b0;
      timer_d = '0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        DELAY: begin
          // Counts down regardless of repeat_en, then parks at 0 until enabled.
          if (timer_q != '0) begin
            timer_d = timer_q - CNT_ONE;
          end else if (bus.repeat_en) begin
            pulse_d = 1'b1;
            timer_d = PERIOD_LOAD;
            state_d = REPEAT;
          end
        end
        REPEAT: begin
          // repeat_en low freezes the timer where it is.
          if (bus.repeat_en) begin
            if (timer_q == '0) begin
              pulse_d = 1'b1;
              timer_d = PERIOD_LOAD;
            end else begin
              timer_d = timer_q - CNT_ONE;
            end
          end
        end
        default: ;
      endcase
    end

    // Hold stretcher: each pulse (re)loads, so back-to-back holds have no gap.
    if (pulse_d) begin
      stable_d = code_d;
      hold_d   = HOLD_LOAD;
    end else if (hold_q == '0) begin
      stable_d = '0;
    end else begin
      hold_d = hold_q - CNT_ONE;
    end
  end

  assign bus.key_pulse  = pulse_q;
  assign bus.key_code   = code_q;
  assign bus.key_ext    = kext_q;
  assign bus.key_down   = down_q;
  assign bus.stable_key = stable_q;
  assign dbg_state      = state_q;

endmodule
